// File: rtl/msp430_fetch_pipeline_pkg.sv
// -----------------------------------------------------------------------------
// msp430_pkg
// Shared definitions for the MSP430 fetch/decode front end:
//   - MAB source / cycle-type select encodings (MAB_SEL)
//   - instruction format encodings (fmt)
//   - status-register flag bit positions
//   - reset value of the instruction register (MOV #0,R3)
//   - fetch sequencer state type
// -----------------------------------------------------------------------------
package msp430_pkg;

    // MAB_SEL encodings; 5..7 are stall cycles
    localparam logic [2:0] SEL_IFETCH = 3'd0;
    localparam logic [2:0] SEL_EXT    = 3'd1;
    localparam logic [2:0] SEL_DATA   = 3'd2;
    localparam logic [2:0] SEL_STACK  = 3'd3;
    localparam logic [2:0] SEL_BRANCH = 3'd4;

    // Instruction format encodings
    localparam logic [1:0] FMT_SINGLE  = 2'd0;
    localparam logic [1:0] FMT_JUMP    = 2'd1;
    localparam logic [1:0] FMT_DOUBLE  = 2'd2;
    localparam logic [1:0] FMT_ILLEGAL = 2'd3;

    // Status register flag positions
    localparam int SR_C = 0;
    localparam int SR_Z = 1;
    localparam int SR_N = 2;
    localparam int SR_V = 8;

    // MOV #0,R3 : harmless instruction held in IR while nothing is fetched
    localparam logic [15:0] NOP_WORD = 16'h4303;

    // Fetch sequencer states
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    // Sign-extended, word-scaled jump offset: {sext(off10), 1'b0}
    function automatic logic [15:0] jump_offset(input logic [9:0] off10);
        jump_offset = {{5{off10[9]}}, off10, 1'b0};
    endfunction

endpackage

// File: rtl/msp430_fetch_pipeline_if.sv
// -----------------------------------------------------------------------------
// msp430_fetch_pipeline_if
// Bus bundle between the fetch/decode stage and its surroundings
// (memory model and execute/register-file logic).
//   slave  modport : seen by the fetch pipeline (consumes RST_VEC, MAB_SEL,
//                    MDB_in, CALC_OUT, reg_SP_in, reg_SR_in; drives MAB, PC,
//                    IR, EXT, MDR, ir_valid and the decode outputs)
//   master modport : seen by the environment driving the pipeline
// -----------------------------------------------------------------------------
interface msp430_fetch_pipeline_if #(
    parameter int W = 16
);
    // Environment -> pipeline
    logic [W-1:0] RST_VEC;
    logic [2:0]   MAB_SEL;
    logic [W-1:0] MDB_in;
    logic [W-1:0] CALC_OUT;
    logic [W-1:0] reg_SP_in;
    logic [W-1:0] reg_SR_in;

    // Pipeline -> environment
    logic [W-1:0] MAB;
    logic [W-1:0] PC;
    logic [W-1:0] IR;
    logic [W-1:0] EXT;
    logic [W-1:0] MDR;
    logic         ir_valid;
    logic [1:0]   fmt;
    logic [3:0]   opcode;
    logic [3:0]   src_reg;
    logic [3:0]   dst_reg;
    logic [1:0]   As;
    logic         Ad;
    logic         BW;
    logic         jmp_taken;
    logic [W-1:0] jmp_target;

    modport slave (
        input  RST_VEC, MAB_SEL, MDB_in, CALC_OUT, reg_SP_in, reg_SR_in,
        output MAB, PC, IR, EXT, MDR, ir_valid, fmt, opcode, src_reg, dst_reg,
               As, Ad, BW, jmp_taken, jmp_target
    );

    modport master (
        output RST_VEC, MAB_SEL, MDB_in, CALC_OUT, reg_SP_in, reg_SR_in,
        input  MAB, PC, IR, EXT, MDR, ir_valid, fmt, opcode, src_reg, dst_reg,
               As, Ad, BW, jmp_taken, jmp_target
    );

endinterface

// File: rtl/msp430_fetch_pipeline_decode.sv
// -----------------------------------------------------------------------------
// msp430_ir_decode
// Purely combinational field decode of the instruction register plus jump
// condition evaluation against the status flags.
//   i_ir        : instruction register
//   i_pc        : current PC (already past the jump word once fetched)
//   i_flag_c/z/n/v : status flags C, Z, N, V
//   o_fmt       : 0 single, 1 jump, 2 double, 3 illegal
//   o_opcode    : format-dependent opcode field
//   o_src_reg, o_dst_reg, o_as, o_ad, o_bw : raw operand fields
//   o_jmp_taken : jump condition true and instruction is a jump
//   o_jmp_target: PC + sext(offset)*2, modulo 2^16
// -----------------------------------------------------------------------------
module msp430_ir_decode
    import msp430_pkg::*;
(
    input  logic [15:0] i_ir,
    input  logic [15:0] i_pc,
    input  logic        i_flag_c,
    input  logic        i_flag_z,
    input  logic        i_flag_n,
    input  logic        i_flag_v,
    output logic [1:0]  o_fmt,
    output logic [3:0]  o_opcode,
    output logic [3:0]  o_src_reg,
    output logic [3:0]  o_dst_reg,
    output logic [1:0]  o_as,
    output logic        o_ad,
    output logic        o_bw,
    output logic        o_jmp_taken,
    output logic [15:0] o_jmp_target
);

    logic [1:0] w_fmt;
    logic [3:0] w_opcode;
    logic       w_cond_true;
    logic       w_jmp_taken;

    // Instruction format from the top opcode nibble
    always_comb begin
        w_fmt = FMT_DOUBLE;
        if (i_ir[15:12] == 4'h0) begin
            w_fmt = FMT_ILLEGAL;
        end else if (i_ir[15:12] == 4'h1) begin
            w_fmt = FMT_SINGLE;
        end else if (i_ir[15:13] == 3'b001) begin
            w_fmt = FMT_JUMP;
        end else begin
            w_fmt = FMT_DOUBLE;
        end
    end

    // Opcode field location depends on the format; illegal words report the
    // raw top nibble (always 0) so the execute stage sees a stable value
    always_comb begin
        w_opcode = 4'h0;
        case (w_fmt)
            FMT_SINGLE: w_opcode = {1'b0, i_ir[9:7]};
            FMT_JUMP:   w_opcode = {1'b0, i_ir[12:10]};
            FMT_DOUBLE: w_opcode = i_ir[15:12];
            default:    w_opcode = i_ir[15:12];
        endcase
    end

    // Jump condition select from IR[12:10]
    always_comb begin
        w_cond_true = 1'b0;
        case (i_ir[12:10])
            3'd0:    w_cond_true = ~i_flag_z;
            3'd1:    w_cond_true = i_flag_z;
            3'd2:    w_cond_true = ~i_flag_c;
            3'd3:    w_cond_true = i_flag_c;
            3'd4:    w_cond_true = i_flag_n;
            3'd5:    w_cond_true = ~(i_flag_n ^ i_flag_v);
            3'd6:    w_cond_true = i_flag_n ^ i_flag_v;
            3'd7:    w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    // Only jump-format words may report a taken jump
    always_comb begin
        w_jmp_taken = 1'b0;
        if (w_fmt == FMT_JUMP) begin
            w_jmp_taken = w_cond_true;
        end else begin
            w_jmp_taken = 1'b0;
        end
    end

    assign o_fmt        = w_fmt;
    assign o_opcode     = w_opcode;
    assign o_src_reg    = i_ir[11:8];
    assign o_dst_reg    = i_ir[3:0];
    assign o_as         = i_ir[5:4];
    assign o_ad         = i_ir[7];
    assign o_bw         = i_ir[6];
    assign o_jmp_taken  = w_jmp_taken;
    assign o_jmp_target = i_pc + jump_offset(i_ir[9:0]);

endmodule

// File: rtl/msp430_fetch_pipeline.sv
// -----------------------------------------------------------------------------
// msp430_fetch_pipeline
// Fetch/decode front end of the MSP430 core model. Owns PC, IR, EXT and MDR,
// drives the memory address bus from the source chosen by MAB_SEL and exposes
// the combinational instruction decode.
//   clk : system clock, rising-edge
//   rst : asynchronous, active-low reset
//   bus : msp430_fetch_pipeline_if.slave
//         inputs  RST_VEC, MAB_SEL, MDB_in, CALC_OUT, reg_SP_in, reg_SR_in
//         outputs MAB, PC, IR, EXT, MDR, ir_valid, fmt, opcode, src_reg,
//                 dst_reg, As, Ad, BW, jmp_taken, jmp_target
// After reset release the first edge loads PC from RST_VEC (LOAD state);
// from then on each edge performs the cycle type selected by MAB_SEL.
// -----------------------------------------------------------------------------
module msp430_fetch_pipeline
    import msp430_pkg::*;
#(
    parameter int          W        = 16,
    parameter logic [15:0] NOP_WORD = msp430_pkg::NOP_WORD
) (
    input  logic                    clk,
    input  logic                    rst,
    msp430_fetch_pipeline_if.slave  bus
);

    fetch_state_t r_state;
    logic [W-1:0] r_pc;
    logic [W-1:0] r_ir;
    logic [W-1:0] r_ext;
    logic [W-1:0] r_mdr;
    logic         r_ir_valid;

    logic [W-1:0] w_mab;
    logic [W-1:0] w_pc_inc;
    logic [W-1:0] w_branch_pc;

    // Both increments wrap naturally at 16 bits; bit0 is left untouched
    assign w_pc_inc    = r_pc + 16'd2;
    assign w_branch_pc = bus.CALC_OUT + 16'd2;

    // Memory address bus source select
    always_comb begin
        w_mab = r_pc;
        if (r_state == ST_LOAD) begin
            w_mab = bus.RST_VEC;
        end else begin
            case (bus.MAB_SEL)
                SEL_IFETCH: w_mab = r_pc;
                SEL_EXT:    w_mab = r_pc;
                SEL_DATA:   w_mab = bus.CALC_OUT;
                SEL_STACK:  w_mab = bus.reg_SP_in;
                SEL_BRANCH: w_mab = bus.CALC_OUT;
                default:    w_mab = r_pc;
            endcase
        end
    end

    // Fetch sequencer and front-end registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_LOAD;
            r_pc       <= 16'h0000;
            r_ir       <= NOP_WORD;
            r_ext      <= 16'h0000;
            r_mdr      <= 16'h0000;
            r_ir_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_pc    <= bus.RST_VEC;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    case (bus.MAB_SEL)
                        SEL_IFETCH: begin
                            r_ir       <= bus.MDB_in;
                            r_pc       <= w_pc_inc;
                            r_ir_valid <= 1'b1;
                        end
                        SEL_EXT: begin
                            r_ext <= bus.MDB_in;
                            r_pc  <= w_pc_inc;
                        end
                        SEL_DATA: begin
                            r_mdr <= bus.MDB_in;
                        end
                        SEL_STACK: begin
                            r_mdr <= bus.MDB_in;
                        end
                        SEL_BRANCH: begin
                            r_ir       <= bus.MDB_in;
                            r_pc       <= w_branch_pc;
                            r_ir_valid <= 1'b1;
                        end
                        default: begin
                            // stall: every register holds
                            r_pc <= r_pc;
                        end
                    endcase
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    msp430_ir_decode u_decode (
        .i_ir         (r_ir),
        .i_pc         (r_pc),
        .i_flag_c     (bus.reg_SR_in[SR_C]),
        .i_flag_z     (bus.reg_SR_in[SR_Z]),
        .i_flag_n     (bus.reg_SR_in[SR_N]),
        .i_flag_v     (bus.reg_SR_in[SR_V]),
        .o_fmt        (bus.fmt),
        .o_opcode     (bus.opcode),
        .o_src_reg    (bus.src_reg),
        .o_dst_reg    (bus.dst_reg),
        .o_as         (bus.As),
        .o_ad         (bus.Ad),
        .o_bw         (bus.BW),
        .o_jmp_taken  (bus.jmp_taken),
        .o_jmp_target (bus.jmp_target)
    );

    assign bus.MAB      = w_mab;
    assign bus.PC       = r_pc;
    assign bus.IR       = r_ir;
    assign bus.EXT      = r_ext;
    assign bus.MDR      = r_mdr;
    assign bus.ir_valid = r_ir_valid;

endmodule

// File: tb/tb_msp430_fetch_pipeline.sv
// -----------------------------------------------------------------------------
// tb_msp430_fetch_pipeline
// Directed bench for the MSP430 fetch/decode front end. Inputs change 2 time
// units after each rising edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_msp430_fetch_pipeline;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    msp430_fetch_pipeline_if #(.W(16)) bus ();

    msp430_fetch_pipeline #(.W(16), .NOP_WORD(16'h4303)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports
    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Directed stimulus
    initial begin
        n_total = 0;
        n_bad   = 0;
        rst           = 1'b0;
        bus.RST_VEC   = 16'hC000;
        bus.MAB_SEL   = 3'd0;
        bus.MDB_in    = 16'h0000;
        bus.CALC_OUT  = 16'h0000;
        bus.reg_SP_in = 16'h0000;
        bus.reg_SR_in = 16'h0000;

        // Reset state, with an edge seen while still in reset
        tick();
        check_eq("rst_pc",    bus.PC, 16'h0000);
        check_eq("rst_ir",    bus.IR, 16'h4303);
        check_eq("rst_ext",   bus.EXT, 16'h0000);
        check_eq("rst_mdr",   bus.MDR, 16'h0000);
        check_eq("rst_valid", {15'd0, bus.ir_valid}, 16'h0000);
        check_eq("load_mab",  bus.MAB, 16'hC000);

        // Boot: first edge after release loads RST_VEC
        rst = 1'b1;
        tick();
        check_eq("boot_pc",    bus.PC, 16'hC000);
        check_eq("boot_mab",   bus.MAB, 16'hC000);
        check_eq("boot_ir",    bus.IR, 16'h4303);
        check_eq("boot_valid", {15'd0, bus.ir_valid}, 16'h0000);

        // Instruction fetch MOV #x,R1 (0x4031)
        bus.MAB_SEL = 3'd0;
        bus.MDB_in  = 16'h4031;
        tick();
        check_eq("if_ir",     bus.IR, 16'h4031);
        check_eq("if_pc",     bus.PC, 16'hC002);
        check_eq("if_valid",  {15'd0, bus.ir_valid}, 16'h0001);
        check_eq("if_fmt",    {14'd0, bus.fmt}, 16'h0002);
        check_eq("if_opcode", {12'd0, bus.opcode}, 16'h0004);
        check_eq("if_src",    {12'd0, bus.src_reg}, 16'h0000);
        check_eq("if_as",     {14'd0, bus.As}, 16'h0003);
        check_eq("if_dst",    {12'd0, bus.dst_reg}, 16'h0001);
        check_eq("if_ad",     {15'd0, bus.Ad}, 16'h0000);
        check_eq("if_bw",     {15'd0, bus.BW}, 16'h0000);
        // Z==0 condition would hold, but a double-operand word never jumps
        check_eq("if_nojmp",  {15'd0, bus.jmp_taken}, 16'h0000);

        // Extension fetch
        bus.MAB_SEL = 3'd1;
        bus.MDB_in  = 16'h0400;
        #1;
        check_eq("ext_mab", bus.MAB, 16'hC002);
        tick();
        check_eq("ext_ext", bus.EXT, 16'h0400);
        check_eq("ext_pc",  bus.PC, 16'hC004);
        check_eq("ext_ir",  bus.IR, 16'h4031);

        // Stack access
        bus.MAB_SEL   = 3'd3;
        bus.reg_SP_in = 16'h0400;
        bus.MDB_in    = 16'h1234;
        #1;
        check_eq("stk_mab", bus.MAB, 16'h0400);
        tick();
        check_eq("stk_mdr", bus.MDR, 16'h1234);
        check_eq("stk_pc",  bus.PC, 16'hC004);

        // Fetch JEQ +2 (0x2402)
        bus.MAB_SEL = 3'd0;
        bus.MDB_in  = 16'h2402;
        tick();
        check_eq("jeq_pc",     bus.PC, 16'hC006);
        check_eq("jeq_fmt",    {14'd0, bus.fmt}, 16'h0001);
        check_eq("jeq_opcode", {12'd0, bus.opcode}, 16'h0001);
        bus.MAB_SEL   = 3'd6;
        bus.reg_SR_in = 16'h0002;
        #1;
        check_eq("jeq_taken_z1", {15'd0, bus.jmp_taken}, 16'h0001);
        check_eq("jeq_target",   bus.jmp_target, 16'hC00A);
        bus.reg_SR_in = 16'h0000;
        #1;
        check_eq("jeq_taken_z0", {15'd0, bus.jmp_taken}, 16'h0000);
        bus.reg_SR_in = 16'h0105;   // Z=0 with C,N,V set: still not taken
        #1;
        check_eq("jeq_taken_cnv", {15'd0, bus.jmp_taken}, 16'h0000);
        bus.reg_SR_in = 16'h0000;

        // Data access
        bus.MAB_SEL  = 3'd2;
        bus.CALC_OUT = 16'h0200;
        bus.MDB_in   = 16'hBEEF;
        #1;
        check_eq("dat_mab", bus.MAB, 16'h0200);
        tick();
        check_eq("dat_mdr", bus.MDR, 16'hBEEF);
        check_eq("dat_pc",  bus.PC, 16'hC006);

        // Illegal-format word
        bus.MAB_SEL = 3'd0;
        bus.MDB_in  = 16'h0123;
        tick();
        check_eq("ill_fmt",   {14'd0, bus.fmt}, 16'h0003);
        check_eq("ill_pc",    bus.PC, 16'hC008);
        check_eq("ill_nojmp", {15'd0, bus.jmp_taken}, 16'h0000);

        // Branch fetch of a single-operand word (0x1085)
        bus.MAB_SEL  = 3'd4;
        bus.CALC_OUT = 16'hC100;
        bus.MDB_in   = 16'h1085;
        #1;
        check_eq("br_mab", bus.MAB, 16'hC100);
        tick();
        check_eq("br_pc",     bus.PC, 16'hC102);
        check_eq("br_ir",     bus.IR, 16'h1085);
        check_eq("br_fmt",    {14'd0, bus.fmt}, 16'h0000);
        check_eq("br_opcode", {12'd0, bus.opcode}, 16'h0001);

        // Stall: nothing moves
        bus.MAB_SEL = 3'd6;
        bus.MDB_in  = 16'hFFFF;
        #1;
        check_eq("stl_mab", bus.MAB, 16'hC102);
        tick();
        check_eq("stl_pc",  bus.PC, 16'hC102);
        check_eq("stl_ir",  bus.IR, 16'h1085);
        check_eq("stl_ext", bus.EXT, 16'h0400);
        check_eq("stl_mdr", bus.MDR, 16'hBEEF);

        // Wrap: branch to 0xFFFC puts PC at 0xFFFE, next fetch wraps to 0
        bus.MAB_SEL  = 3'd4;
        bus.CALC_OUT = 16'hFFFC;
        bus.MDB_in   = 16'h4303;
        tick();
        check_eq("wrp_pc0", bus.PC, 16'hFFFE);
        bus.MAB_SEL = 3'd0;
        tick();
        check_eq("wrp_pc1", bus.PC, 16'h0000);

        // JMP -1 word (0x3FFF): always taken, target wraps to 0
        bus.MDB_in = 16'h3FFF;
        tick();
        bus.MAB_SEL = 3'd6;
        #1;
        check_eq("jmp_pc",     bus.PC, 16'h0002);
        check_eq("jmp_taken",  {15'd0, bus.jmp_taken}, 16'h0001);
        check_eq("jmp_target", bus.jmp_target, 16'h0000);

        // Async reset mid-cycle, away from any edge
        bus.MAB_SEL = 3'd0;
        bus.MDB_in  = 16'h4031;
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_pc",    bus.PC, 16'h0000);
        check_eq("arst_ir",    bus.IR, 16'h4303);
        check_eq("arst_valid", {15'd0, bus.ir_valid}, 16'h0000);
        bus.RST_VEC = 16'h8000;
        #1;
        check_eq("arst_mab", bus.MAB, 16'h8000);
        tick();
        check_eq("arst_hold_pc", bus.PC, 16'h0000);
        check_eq("arst_hold_ir", bus.IR, 16'h4303);

        // Release: first edge reloads RST_VEC only
        rst = 1'b1;
        tick();
        check_eq("rel_pc",    bus.PC, 16'h8000);
        check_eq("rel_ir",    bus.IR, 16'h4303);
        check_eq("rel_valid", {15'd0, bus.ir_valid}, 16'h0000);
        tick();
        check_eq("rel_if_pc", bus.PC, 16'h8002);
        check_eq("rel_if_ir", bus.IR, 16'h4031);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/msp430_fetch_pipeline.md
Name: msp430_fetch_pipeline

Overview:
- Front-end fetch/decode stage of the MSP430 core model.
- Owns the program counter, instruction register (IR), extension-word register (EXT) and memory-data latch (MDR).
- Drives the memory address bus (MAB) from a selectable source.
- Decodes IR fields and evaluates jump conditions against the status register. It sits between the memory model (MAB/MDB) and the execute/register-file logic, which supplies CALC_OUT, reg_SP_in, reg_SR_in and MAB_SEL.

Parameters:
- W, 16, data and address width (fixed at 16 for MSP430; only the value 16 is verified).
- NOP_WORD, 16'h4303, value loaded into IR at reset (MOV #0,R3).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-low.
- RST_VEC  in  16  PC value loaded on the first clock edge after reset release.
- MAB_SEL  in  3  MAB source / cycle-type select (see Behaviour).
- MDB_in  in  16  memory data bus read; combinational response to MAB in the same cycle.
- CALC_OUT  in  16  computed address from execute (data address or branch target).
- reg_SP_in  in  16  current R1/SP value.
- reg_SR_in  in  16  current R2/SR value (C=bit0, Z=bit1, N=bit2, V=bit8).
- MAB  out  16  memory address bus.
- PC  out  16  program counter.
- IR  out  16  instruction register.
- EXT  out  16  last fetched extension word.
- MDR  out  16  last data/stack read word.
- ir_valid  out  1  IR holds a fetched instruction.
- fmt  out  2  0 single-operand, 1 jump, 2 double-operand, 3 illegal.
- opcode  out  4  double: IR[15:12]; single: {1'b0,IR[9:7]}; jump: {1'b0,IR[12:10]}.
- src_reg  out  4  IR[11:8].
- dst_reg  out  4  IR[3:0].
- As  out  2  IR[5:4].
- Ad  out  1  IR[7].
- BW  out  1  IR[6].
- jmp_taken  out  1  jump condition true and fmt==1.
- jmp_target  out  16  PC + {sext(IR[9:0]),1'b0}, mod 2^16.

Behaviour:
- Reset, while rst==0, asynchronous and immediate:
  - PC=0, IR=NOP_WORD, EXT=0, MDR=0, ir_valid=0.
  - Internal state=LOAD.
- State LOAD:
  - MAB=RST_VEC; MAB_SEL is ignored.
  - On the first rising edge with rst==1: PC<=RST_VEC, state<=RUN.
  - No other register changes.
- State RUN, MAB_SEL decoding (MAB is combinational; updates occur on the rising edge):
  - 0 instruction fetch: MAB=PC; IR<=MDB_in, PC<=PC+2, ir_valid<=1.
  - 1 extension fetch: MAB=PC; EXT<=MDB_in, PC<=PC+2.
  - 2 data access: MAB=CALC_OUT; MDR<=MDB_in.
  - 3 stack access: MAB=reg_SP_in; MDR<=MDB_in.
  - 4 branch fetch: MAB=CALC_OUT; IR<=MDB_in, PC<=CALC_OUT+2, ir_valid<=1.
  - 5-7 stall: MAB=PC; all registers hold.
- PC arithmetic wraps modulo 2^16 (0xFFFE+2 = 0x0000). PC bit0 is not forced; odd values propagate unchanged.
- fmt decode:
  - IR[15:12]==0 → 3.
  - IR[15:12]==1 → 0.
  - IR[15:13]==3'b001 → 1.
  - otherwise → 2.
- Decode outputs and jmp_target are purely combinational from IR, PC and reg_SR_in; no added latency.
- Jump conditions, cond=IR[12:10]:
  - 0 Z==0, 1 Z==1, 2 C==0, 3 C==1, 4 N==1, 5 (N^V)==0, 6 (N^V)==1, 7 always.
- jmp_taken=0 whenever fmt!=1.
- jmp_target uses the current PC, which points past the jump word once it has been fetched.
- Reset asserted mid-operation overrides any MAB_SEL action in the same cycle.

Decomposition:
- Shared package msp430_pkg:
  - MAB_SEL encodings (SEL_IFETCH=0, SEL_EXT=1, SEL_DATA=2, SEL_STACK=3, SEL_BRANCH=4).
  - fmt encodings.
  - SR bit indices.
  - NOP_WORD.
- One natural sub-module: msp430_ir_decode, the combinational field decode plus jump-condition evaluation.

Test Plan:
- Reset/boot: rst=0, RST_VEC=0xC000, then rst=1 → PC=0 and IR=0x4303 during reset; after first edge PC=0xC000 and MAB=0xC000.
- Instruction fetch: MAB_SEL=0, MDB_in=0x4031 → IR=0x4031, PC=0xC002, fmt=2, opcode=4, src_reg=0, As=3, dst_reg=1, Ad=0, BW=0, ir_valid=1.
- Extension and stack access:
  - MAB_SEL=1, MDB_in=0x0400 → EXT=0x0400, PC=0xC004.
  - Then MAB_SEL=3, reg_SP_in=0x0400 → MAB=0x0400; MDR takes MDB_in; PC unchanged.
- Jump: PC=0xC006, IR=0x2402 (JEQ +2):
  - reg_SR_in=0x0002 → jmp_taken=1, jmp_target=0xC00A.
  - reg_SR_in=0 → jmp_taken=0.
- Branch and stall:
  - MAB_SEL=4, CALC_OUT=0xC100 → MAB=0xC100, PC=0xC102, IR=MDB_in.
  - MAB_SEL=6 → all registers hold.
  - Wrap: PC=0xFFFE with fetch → PC=0x0000.
- Async reset mid-run: drop rst between edges → PC=0, IR=0x4303, ir_valid=0 immediately; the next edge after release reloads RST_VEC.
